// File: rtl/zz_video_pkg.sv
// Shared video-path definitions: formatter opcodes, colour modes, sprite geometry
// and the control sequencer state encoding.
package zz_video_pkg;

  localparam logic [7:0] OP_NOP         = 8'd0;
  localparam logic [7:0] OP_COLORMODE   = 8'd1;
  localparam logic [7:0] OP_DIMENSIONS  = 8'd2;
  localparam logic [7:0] OP_PAN         = 8'd3;
  localparam logic [7:0] OP_SCALE       = 8'd4;
  localparam logic [7:0] OP_POWER       = 8'd5;
  localparam logic [7:0] OP_MAX         = 8'd6;
  localparam logic [7:0] OP_HS          = 8'd7;
  localparam logic [7:0] OP_VS          = 8'd8;
  localparam logic [7:0] OP_SCREENW     = 8'd9;
  localparam logic [7:0] OP_POLARITY    = 8'd10;
  localparam logic [7:0] OP_RESET       = 8'd11;
  localparam logic [7:0] OP_SPRITE_XY   = 8'd12;
  localparam logic [7:0] OP_SPRITE_COLS = 8'd13;
  localparam logic [7:0] OP_SPRITE_ADDR = 8'd14;
  localparam logic [7:0] OP_SPRITE_DATA = 8'd15;
  localparam logic [7:0] OP_VSYNC       = 8'd16;
  localparam logic [7:0] OP_SPRITE_CLR  = 8'd17;

  localparam logic [1:0] CMODE_8BIT  = 2'd0;
  localparam logic [1:0] CMODE_16BIT = 2'd1;
  localparam logic [1:0] CMODE_32BIT = 2'd2;
  localparam logic [1:0] CMODE_15BIT = 2'd3;

  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SADDR,
    ST_SGAP,
    ST_DRIVE,
    ST_GAP,
    ST_WAIT_VB
  } vcs_state_e;

  // Timing ops that must only take effect during vertical blanking.
  function automatic logic is_vb_deferred(input logic [7:0] op);
    return (op == OP_COLORMODE) || (op == OP_DIMENSIONS) || (op == OP_SCALE) ||
           (op == OP_MAX) || (op == OP_HS) || (op == OP_VS);
  endfunction

endpackage

// File: rtl/video_ctrl_sequencer_if.sv
// Requester command ports and formatter control bus of video_ctrl_sequencer.
interface video_ctrl_sequencer_if;
  logic        req0_valid;
  logic [7:0]  req0_op;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_op;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [7:0]  control_op;
  logic [31:0] control_data;

  modport master (
    output req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
    input  req0_ready, req1_ready, control_op, control_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
    output req0_ready, req1_ready, control_op, control_data
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grants are combinational, last_grant is registered
// and resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic last_q;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i && rst_ni) begin
      if (req0_i && (!req1_i || last_q)) gnt0_o = 1'b1;
      else if (req1_i)                   gnt1_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     last_q <= 1'b1;
    else if (gnt0_o) last_q <= 1'b0;
    else if (gnt1_o) last_q <= 1'b1;
  end
endmodule

// File: rtl/video_ctrl_sequencer.sv
// Serialises requester commands onto the formatter control bus with hold/gap framing
// and sprite address expansion. Optional VCS_VBLANK_DEFER_EN defers timing ops to vblank.
module video_ctrl_sequencer
  import zz_video_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned SPRITE_WORDS = 1536
) (
  input  logic                    m_axis_vid_aclk,
  input  logic                    aresetn,
  video_ctrl_sequencer_if.slave   bus,
  input  logic                    vblank_async,
  output logic                    busy
);
  localparam logic [3:0]  HOLD_RL  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0]  GAP_RL   = 4'(GAP_CYCLES - 1);
  localparam logic [11:0] SPR_LAST = 12'(SPRITE_WORDS - 1);

  vcs_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cmd_op_q;
  logic [31:0] cmd_data_q;
  logic [11:0] spr_ptr_q;
  logic [7:0]  ctrl_op_q;
  logic [31:0] ctrl_data_q;

  logic        idle, gnt0, gnt1, accept, defer, vb_rise;
  logic [7:0]  acc_op;
  logic [31:0] acc_data;

  assign idle = (state_q == ST_IDLE);

  rr_arbiter2 u_arb (
    .clk_i  (m_axis_vid_aclk),
    .rst_ni (aresetn),
    .en_i   (idle),
    .req0_i (bus.req0_valid),
    .req1_i (bus.req1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign accept           = gnt0 | gnt1;
  assign acc_op           = gnt1 ? bus.req1_op   : bus.req0_op;
  assign acc_data         = gnt1 ? bus.req1_data : bus.req0_data;
  assign bus.control_op   = ctrl_op_q;
  assign bus.control_data = ctrl_data_q;
  assign busy             = !idle;

`ifdef VCS_VBLANK_DEFER_EN
  logic vb_s1_q, vb_s2_q, vb_s3_q;

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      vb_s1_q <= 1'b0;
      vb_s2_q <= 1'b0;
      vb_s3_q <= 1'b0;
    end else begin
      vb_s1_q <= vblank_async;
      vb_s2_q <= vb_s1_q;
      vb_s3_q <= vb_s2_q;
    end
  end

  assign vb_rise = vb_s2_q & ~vb_s3_q;
  assign defer   = is_vb_deferred(acc_op);
`else
  logic vblank_unused;
  assign vblank_unused = vblank_async;
  assign vb_rise       = 1'b0;
  assign defer         = 1'b0;
`endif

  always_ff @(posedge m_axis_vid_aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_op_q    <= '0;
      cmd_data_q  <= '0;
      spr_ptr_q   <= '0;
      ctrl_op_q   <= '0;
      ctrl_data_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) begin
          cmd_op_q   <= acc_op;
          // An accepted NOP must leave the bus fully idle, data included.
          cmd_data_q <= (acc_op == OP_NOP) ? '0 : acc_data;
          if (acc_op == OP_SPRITE_ADDR)
            spr_ptr_q <= (acc_data >= 32'(SPRITE_WORDS)) ? '0 : acc_data[11:0];
          if (acc_op == OP_SPRITE_DATA) begin
            state_q     <= ST_SADDR;
            ctrl_op_q   <= OP_SPRITE_ADDR;
            ctrl_data_q <= {20'b0, spr_ptr_q};
            cnt_q       <= HOLD_RL;
          end else if (defer) begin
            state_q <= ST_WAIT_VB;
            cnt_q   <= HOLD_RL;
          end else begin
            state_q     <= ST_DRIVE;
            ctrl_op_q   <= acc_op;
            ctrl_data_q <= (acc_op == OP_NOP) ? '0 : acc_data;
            cnt_q       <= HOLD_RL;
          end
        end
        ST_SADDR: if (cnt_q == '0) begin
          state_q     <= ST_SGAP;
          ctrl_op_q   <= '0;
          ctrl_data_q <= '0;
          cnt_q       <= GAP_RL;
        end else cnt_q <= cnt_q - 4'd1;
        ST_SGAP: if (cnt_q == '0) begin
          state_q     <= ST_DRIVE;
          ctrl_op_q   <= cmd_op_q;
          ctrl_data_q <= cmd_data_q;
          cnt_q       <= HOLD_RL;
        end else cnt_q <= cnt_q - 4'd1;
        ST_DRIVE: if (cnt_q == '0) begin
          state_q     <= ST_GAP;
          ctrl_op_q   <= '0;
          ctrl_data_q <= '0;
          cnt_q       <= GAP_RL;
          if (cmd_op_q == OP_SPRITE_DATA)
            spr_ptr_q <= (spr_ptr_q == SPR_LAST) ? '0 : spr_ptr_q + 12'd1;
        end else cnt_q <= cnt_q - 4'd1;
        ST_GAP: if (cnt_q == '0) state_q <= ST_IDLE;
                else cnt_q <= cnt_q - 4'd1;
        ST_WAIT_VB: if (vb_rise) begin
          state_q     <= ST_DRIVE;
          ctrl_op_q   <= cmd_op_q;
          ctrl_data_q <= cmd_data_q;
          cnt_q       <= HOLD_RL;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
